// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin between a read-only fetch port and a
// read/write data port, with a bounded wait on the memory ready bit.
module mem_arbiter #(
    parameter int AddrBusSize   = 16,
    parameter int ElementSize   = 16,
    parameter int TimeoutCycles = 16
) (
    input  logic                   i_CLK,
    input  logic                   i_RST_N,
    input  logic                   i_if_req,
    input  logic [AddrBusSize-1:0] i_if_addr,
    output logic                   o_if_ack,
    output logic [ElementSize-1:0] o_if_data,
    input  logic                   i_dm_req,
    input  logic                   i_dm_we,
    input  logic [AddrBusSize-1:0] i_dm_addr,
    input  logic [ElementSize-1:0] i_dm_wdata,
    output logic                   o_dm_ack,
    output logic [ElementSize-1:0] o_dm_rdata,
    output logic                   o_err,
    output logic                   o_busy,
    output logic                   o_grant,
    output logic                   o_mem_read_en,
    output logic                   o_mem_write_en,
    output logic [AddrBusSize-1:0] o_mem_read_addr,
    output logic [AddrBusSize-1:0] o_mem_write_addr,
    output logic [ElementSize-1:0] o_mem_write_data,
    input  logic                   i_mem_ready,
    input  logic [ElementSize-1:0] i_mem_read_data
);
    localparam int CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [CntW-1:0]        to_cnt;
    logic                   last_dm;
    logic                   lat_we;
    logic                   any_req;
    logic                   win_dm;
    logic                   win_we;
    logic                   timed_out;
    logic [AddrBusSize-1:0] win_addr;

    // On a tie the port that did not win last time gets the grant.
    assign any_req   = i_if_req | i_dm_req;
    assign win_dm    = (i_if_req & i_dm_req) ? ~last_dm : i_dm_req;
    assign win_we    = win_dm & i_dm_we;
    assign win_addr  = win_dm ? i_dm_addr : i_if_addr;
    assign timed_out = (to_cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state            <= IDLE;
            to_cnt           <= '0;
            last_dm          <= 1'b1;
            lat_we           <= 1'b0;
            o_if_ack         <= 1'b0;
            o_if_data        <= '0;
            o_dm_ack         <= 1'b0;
            o_dm_rdata       <= '0;
            o_err            <= 1'b0;
            o_busy           <= 1'b0;
            o_grant          <= 1'b0;
            o_mem_read_en    <= 1'b0;
            o_mem_write_en   <= 1'b0;
            o_mem_read_addr  <= '0;
            o_mem_write_addr <= '0;
            o_mem_write_data <= '0;
        end else begin
            o_if_ack <= 1'b0;
            o_dm_ack <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req && !i_mem_ready) begin
                        state            <= BUSY;
                        to_cnt           <= '0;
                        o_busy           <= 1'b1;
                        o_grant          <= win_dm;
                        last_dm          <= win_dm;
                        lat_we           <= win_we;
                        o_mem_read_en    <= ~win_we;
                        o_mem_write_en   <= win_we;
                        o_mem_read_addr  <= win_addr;
                        o_mem_write_addr <= win_addr;
                        o_mem_write_data <= win_we ? i_dm_wdata : '0;
                    end
                end
                BUSY: begin
                    // Ready has priority over a timeout landing on the same edge.
                    if (i_mem_ready || timed_out) begin
                        state          <= DONE;
                        o_busy         <= 1'b0;
                        o_mem_read_en  <= 1'b0;
                        o_mem_write_en <= 1'b0;
                        o_err          <= ~i_mem_ready;
                        if (o_grant) begin
                            o_dm_ack <= 1'b1;
                            if (!lat_we)
                                o_dm_rdata <= i_mem_ready ? i_mem_read_data : '0;
                        end else begin
                            o_if_ack  <= 1'b1;
                            o_if_data <= i_mem_ready ? i_mem_read_data : '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + CntW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AddrBusSize, default 16: width of all address buses.
REQ-002 Parameter ElementSize, default 16: width of all data buses.
REQ-003 Parameter TimeoutCycles, default 16: maximum BUSY cycles to wait for i_mem_ready; SHALL be at least 2.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- i_CLK  in  1  sole clock, rising edge.
- i_RST_N  in  1  asynchronous active-low reset.
- i_if_req  in  1  fetch read request (read-only requester).
- i_if_addr  in  AddrBusSize  fetch address.
- o_if_ack  out  1  one-cycle fetch completion pulse.
- o_if_data  out  ElementSize  fetch read data, valid with o_if_ack.
- i_dm_req  in  1  data-port request.
- i_dm_we  in  1  data-port write select: 1 = write, 0 = read.
- i_dm_addr  in  AddrBusSize  data-port address.
- i_dm_wdata  in  ElementSize  data-port write data.
- o_dm_ack  out  1  one-cycle data-port completion pulse.
- o_dm_rdata  out  ElementSize  data-port read data, valid with o_dm_ack.
- o_err  out  1  one-cycle timeout pulse, coincident with the ack.
- o_busy  out  1  high while a transaction is granted.
- o_grant  out  1  owner of the current or last grant: 0 = fetch, 1 = data.
- o_mem_read_en, o_mem_write_en  out  1  memory enables.
- o_mem_read_addr, o_mem_write_addr  out  AddrBusSize  memory addresses.
- o_mem_write_data  out  ElementSize  memory write data.
- i_mem_ready  in  1  memory completion bit.
- i_mem_read_data  in  ElementSize  memory read data.

Function
REQ-005 The FSM SHALL have three states: IDLE, BUSY and DONE. All outputs SHALL be registered.
REQ-006 IDLE SHALL grant only when at least one request is high and i_mem_ready == 0; with i_mem_ready high it SHALL stay in IDLE.
REQ-007 Arbitration SHALL be round-robin:
- A single requester wins.
- If both request, the winner is the requester that was not the last grantee.
- The last-grantee register resets to data, so fetch wins the first tie.
REQ-008 On grant, address, we and wdata SHALL be latched internally; requester inputs are don't-care after the grant edge.
REQ-009 From the grant edge, the BUSY state SHALL drive the enables and latched operands to memory:
- Fetch or data read: o_mem_read_en = 1.
- Data write: o_mem_write_en = 1.
- Both address outputs carry the latched address.
- Both enables are never high together.
REQ-010 BUSY SHALL hold the enables until i_mem_ready is sampled high. On that edge:
- Enables deassert.
- Read data is captured from i_mem_read_data into the granted port's data output.
- The granted port's ack pulses for exactly one cycle.
- The FSM moves to DONE.
REQ-011 DONE SHALL last exactly one cycle with enables low, then return to IDLE; a new grant is therefore at least 2 cycles after an ack.
REQ-012 A timeout counter SHALL clear on grant and increment each BUSY cycle. If it reaches TimeoutCycles with i_mem_ready low, the block SHALL:
- Deassert the enables.
- Pulse the ack together with o_err.
- Drive zero on the read data output.
- Go to DONE.
REQ-013 o_if_data and o_dm_rdata SHALL hold their values between acks; a write ack SHALL leave o_dm_rdata unchanged.
REQ-014 o_busy SHALL be 1 in BUSY only; o_grant SHALL update on the grant edge and otherwise hold.
REQ-015 A request asserted during BUSY or DONE SHALL wait, with no loss, until IDLE.
REQ-016 If i_mem_ready and timeout occur on the same edge, ready SHALL win: normal ack, no o_err.

Reset
REQ-017 While i_RST_N = 0, asynchronously:
- State = IDLE.
- All outputs = 0, including data outputs and o_grant.
- Timeout counter = 0.
- Last grantee = data.
REQ-018 A reset asserted mid-transaction SHALL abort it with no ack, and the enables SHALL be low immediately.
REQ-019 After reset release, the first grant SHALL occur no earlier than the first rising edge with i_RST_N = 1.

Verification
REQ-020 Fetch read, addr 0x0010 holding 0x1234, memory ready 2 cycles after read_en -> o_mem_read_en high 3 cycles, o_if_ack pulses 1 cycle with o_if_data = 0x1234, o_err = 0.
REQ-021 Data write, addr 0x0020, data 0xBEEF, ready 1 cycle after write_en -> o_mem_write_en high 2 cycles, o_dm_ack pulses; a subsequent data read of 0x0020 returns 0xBEEF.
REQ-022 Fetch and data requests held high together from reset -> grant order fetch, data, fetch, data; each ack 1 cycle; never both enables high.
REQ-023 Memory never asserts ready -> after 16 BUSY cycles, ack and o_err pulse together, data output = 0x0000, FSM returns to IDLE and serves the next request.
REQ-024 i_mem_ready held high after DONE -> no grant until it falls; i_RST_N pulsed low mid-BUSY -> enables low at once, no ack, outputs zero.
